popcount_rr_arbiter: RTL and testbench
======================================

POPCOUNT_RR_ARBITER -- requirements
Module: popcount_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, is the data word width of each requester.
REQ-002 Parameter REQ_CNT, default 4, is the number of requesters; the legal range is 2..16.
REQ-003 Parameter TAG_DEPTH, default 8, is the maximum number of outstanding words in the shared counter; it SHALL be a power of two and at least 2.
REQ-004 clk_i  input  1  is the single clock; all logic is on the rising edge.
REQ-005 srst_i  input  1  is the reset, which is synchronous and active-high.
REQ-006 req_data_i  input  REQ_CNT x WIDTH  carries the word from each requester.
REQ-007 req_val_i  input  REQ_CNT  is the per-requester word-valid signal.
REQ-008 req_ready_o  output  REQ_CNT  is the per-requester accept signal; it is at most one-hot.
REQ-009 data_o  output  $clog2(WIDTH)+1  is the number of ones in the accepted word.
REQ-010 id_o  output  $clog2(REQ_CNT)  is the index of the requester that owns data_o.
REQ-011 data_val_o  output  1  qualifies data_o and id_o for exactly one cycle.
REQ-012 err_o  output  1  is a sticky flag for a counter result that arrives with no tag outstanding.

Function
REQ-013 A transfer SHALL occur on requester k when req_val_i[k] and req_ready_o[k] are both high in the same cycle; there SHALL be at most one transfer per cycle.
REQ-014 The grant SHALL be round-robin: the granted requester is the first valid index at or after the pointer, searching with wrap-around modulo REQ_CNT.
REQ-015 After each transfer, the pointer SHALL move to the granted index plus 1, modulo REQ_CNT; the pointer SHALL hold while no transfer occurs.
REQ-016 req_ready_o SHALL be combinational from req_val_i, the pointer and the tag-FIFO full flag.
REQ-017 req_ready_o SHALL be all-zero while the tag FIFO is full, including in a cycle where a pop is also occurring.
REQ-018 The accepted word SHALL be registered and presented to the shared counter with its data_val_i asserted on the cycle after the transfer.
REQ-019 The requester index SHALL be pushed into the tag FIFO in the transfer cycle.
REQ-020 When the counter asserts data_val_o, the tag FIFO SHALL pop, and on the next cycle data_o, id_o and data_val_o=1 SHALL be registered.
REQ-021 End-to-end latency SHALL be the counter latency plus 2 cycles; results SHALL be returned in acceptance order.
REQ-022 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-023 A counter result with the FIFO empty SHALL set err_o, produce data_val_o=0, and leave the FIFO unchanged.
REQ-024 err_o SHALL clear only on reset.
REQ-025 The output has no backpressure; every counter result SHALL be forwarded.
REQ-026 While data_val_o is low, data_o and id_o SHALL hold their last values.

Reset
REQ-027 On srst_i high, the pointer, FIFO pointers and FIFO count, data_o, id_o, data_val_o and err_o SHALL all become 0 at the next edge.
REQ-028 The counter's data_val_i register SHALL become 0 on reset.
REQ-029 While srst_i is high, req_ready_o SHALL be all-zero.
REQ-030 The shared counter SHALL be reset by the same srst_i; words in flight at reset SHALL be discarded with no output.

Structure
REQ-031 A shared package SHALL hold the id-width and count-width helper functions and the TAG_DEPTH default.
REQ-032 The block SHALL instantiate one bit_population_counter as its sole sub-module.
REQ-033 The round-robin grant logic and the tag FIFO SHALL be inline logic in this block.

Verification
REQ-034 Single requester 2 sends 0xFFFF_FFFF → after counter latency+2 cycles, data_o=32, id_o=2, data_val_o=1 for 1 cycle.
REQ-035 All 4 requesters valid continuously with pointer 0 → grants go 0,1,2,3,0,…; id_o follows the same sequence with no gaps.
REQ-036 Requesters 1 and 3 valid, pointer 2 → requester 3 is granted first, then 1.
REQ-037 The counter is stalled until 8 words are outstanding → req_ready_o=0; accept resumes in the cycle after the first pop.
REQ-038 Reset is asserted with 3 words in flight → no data_val_o afterwards, FIFO empty, and the next word is granted from pointer 0.
REQ-039 A counter data_val_o is forced with the FIFO empty → err_o=1 and stays high, and data_val_o=0.

Source files
------------

// File: rtl/popcount_rr_arbiter_pkg.sv
// popcount_rr_arbiter_pkg: shared width helpers and defaults for the popcount arbiter
package popcount_rr_arbiter_pkg;
  localparam int TAG_DEPTH_DEF = 8;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/bit_population_counter.sv
// bit_population_counter: counts ones in a word, result valid LATENCY cycles after data_val_i
module bit_population_counter
  import popcount_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          data_val_i,
  output logic [count_width(WIDTH)-1:0] data_o,
  output logic                          data_val_o
);
  localparam int CW = count_width(WIDTH);
  logic [CW-1:0] ones;
  logic [CW-1:0] cnt_pipe [LATENCY];
  logic [LATENCY-1:0] val_pipe;
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) ones = ones + CW'(data_i[i]);
  end
  always_ff @(posedge clk_i) begin
    cnt_pipe[0] <= ones;
    val_pipe[0] <= srst_i ? 1'b0 : data_val_i;
    for (int i = 1; i < LATENCY; i++) begin
      cnt_pipe[i] <= cnt_pipe[i-1];
      val_pipe[i] <= srst_i ? 1'b0 : val_pipe[i-1];
    end
  end
  assign data_o = cnt_pipe[LATENCY-1];
  assign data_val_o = val_pipe[LATENCY-1];
endmodule

// File: rtl/popcount_rr_arbiter.sv
// popcount_rr_arbiter: round-robin arbiter feeding a shared popcounter, results tagged
// with the requester index through an in-order tag FIFO
module popcount_rr_arbiter
  import popcount_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REQ_CNT = 4,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  parameter int CNT_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             srst_i,
  input  logic [REQ_CNT-1:0][WIDTH-1:0]    req_data_i,
  input  logic [REQ_CNT-1:0]               req_val_i,
  output logic [REQ_CNT-1:0]               req_ready_o,
  output logic [count_width(WIDTH)-1:0]    data_o,
  output logic [id_width(REQ_CNT)-1:0]     id_o,
  output logic                             data_val_o,
  output logic                             err_o
);
  localparam int IW = id_width(REQ_CNT);
  localparam int CW = count_width(WIDTH);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int NW = AW + 1;
  logic [IW-1:0] ptr, cand, gnt_idx;
  logic gnt_any, full, empty, xfer, pop;
  logic [WIDTH-1:0] word_q;
  logic word_val_q;
  logic [CW-1:0] cnt_data;
  logic cnt_val;
  logic [IW-1:0] tags [TAG_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  // descending scan so the valid requester closest to ptr wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand = '0;
    for (int i = REQ_CNT - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % REQ_CNT);
      if (req_val_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  // count never exceeds TAG_DEPTH (a power of two), so its MSB alone flags full
  assign full = count[AW];
  assign empty = (count == '0);
  assign req_ready_o = (gnt_any && !full && !srst_i) ? (REQ_CNT'(1) << gnt_idx) : '0;
  assign xfer = |req_ready_o;
  assign pop = cnt_val && !empty;
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      word_q <= req_data_i[gnt_idx];
      tags[wr_ptr] <= gnt_idx;
    end
    if (srst_i) begin
      ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      word_val_q <= 1'b0;
      data_o <= '0;
      id_o <= '0;
      data_val_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      word_val_q <= xfer;
      data_val_o <= pop;
      err_o <= err_o | (cnt_val & empty);
      count <= count + NW'(xfer) - NW'(pop);
      if (xfer) begin
        ptr <= (gnt_idx == IW'(REQ_CNT - 1)) ? '0 : gnt_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_o <= cnt_data;
        id_o <= tags[rd_ptr];
      end
    end
  end
  bit_population_counter #(.WIDTH(WIDTH), .LATENCY(CNT_LATENCY)) u_cnt (
    .clk_i(clk_i),
    .srst_i(srst_i),
    .data_i(word_q),
    .data_val_i(word_val_q),
    .data_o(cnt_data),
    .data_val_o(cnt_val)
  );
endmodule

// File: tb/tb_popcount_rr_arbiter.sv
// tb_popcount_rr_arbiter: random and directed traffic against a queue-based reference model
module tb_popcount_rr_arbiter;
  localparam int N = 4, W = 32, DEPTH = 8, LAT = 7;
  logic clk = 1'b0;
  logic srst;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0] req_val, req_ready, rdy_exp;
  logic [5:0] data_o;
  logic [1:0] id_o;
  logic data_val, err;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct { int d; int id; int due; } exp_t;
  exp_t q[$];
  exp_t e;
  int acc[$];
  int ptr = 0, last_d = 0, last_id = 0, g;
  logic err_exp = 1'b0, chk_en = 1'b0, inj = 1'b0;

  popcount_rr_arbiter #(.WIDTH(W), .REQ_CNT(N), .TAG_DEPTH(DEPTH), .CNT_LATENCY(LAT)) dut (
    .clk_i(clk),
    .srst_i(srst),
    .req_data_i(req_data),
    .req_val_i(req_val),
    .req_ready_o(req_ready),
    .data_o(data_o),
    .id_o(id_o),
    .data_val_o(data_val),
    .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // reference: grant from the model pointer, occupancy from acceptance times
  always @(negedge clk) begin
    while (acc.size() != 0 && acc[0] + LAT + 1 < cyc) void'(acc.pop_front());
    g = -1;
    if (!srst && acc.size() < DEPTH)
      for (int i = 0; i < N; i++)
        if (g < 0 && req_val[2'((ptr + i) % N)]) g = (ptr + i) % N;
    rdy_exp = (g < 0) ? '0 : (4'(1) << g);
    chk("ready", req_ready, rdy_exp);
    if (g >= 0) begin
      q.push_back('{$countones(req_data[2'(g)]), g, cyc + LAT + 2});
      acc.push_back(cyc);
      ptr = (g + 1) % N;
    end
    if (srst) begin
      while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
      acc.delete();
      ptr = 0;
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_val", data_val, q.size() != 0 && q[0].due == cyc);
      if (data_val && q.size() != 0) begin
        e = q.pop_front();
        chk("data", data_o, e.d);
        chk("id", id_o, e.id);
        last_d = e.d;
        last_id = e.id;
      end else begin
        if (!data_val && q.size() != 0 && q[0].due <= cyc) void'(q.pop_front());
        chk("hold_data", data_o, last_d);
        chk("hold_id", id_o, last_id);
      end
      chk("err", err, err_exp);
      if (inj) err_exp = 1'b1;
    end
    if (srst) begin
      last_d = 0;
      last_id = 0;
      err_exp = 1'b0;
      chk_en = 1'b1;
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic r);
    srst = r;
    req_val = v;
    for (int k = 0; k < N; k++) req_data[k] = $urandom();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive('0, 1'b1);
    drive('0, 1'b1);
    srst = 1'b0;
    req_val = 4'b0100;
    req_data[2] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    repeat (12) drive('0, 1'b0);
    repeat (6) drive(4'hF, 1'b0);
    repeat (12) drive('0, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b1010, 1'b0);
    drive(4'b1010, 1'b0);
    repeat (12) drive('0, 1'b0);
    repeat (300) drive(4'($urandom()), 1'b0);
    repeat (40) drive(4'hF, 1'b0);
    drive(4'hF, 1'b1);
    repeat (12) drive('0, 1'b0);
    drive(4'b1010, 1'b0);
    repeat (12) drive('0, 1'b0);
    req_val = '0;
    inj = 1'b1;
    force dut.cnt_val = 1'b1;
    @(posedge clk);
    #1;
    release dut.cnt_val;
    inj = 1'b0;
    repeat (5) drive('0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
